uart_frame_parser: RTL and testbench

- Sits directly downstream of top_uart.
- Pops received bytes from the UART RX FIFO using rd_en/data_out semantics and delineates framed messages: SOF, LEN, payload, XOR checksum.
- Buffers the payload and streams it out only after the checksum passes.
- Reports length, checksum and inter-byte timeout errors, and keeps frame and error counters.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_frame_buf.sv | 37 +++
 rtl/uart_frame_parser.sv | 195 +++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART frame parser slice: the parser state
//   encoding, default framing constants and the statistics counter width.
package uart_pkg;

  // Parser states: hunt for SOF, take length, collect payload, verify
  // checksum, then stream the buffered payload out.
  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHK,
    DRAIN
  } state_t;

  localparam int         DEFAULT_MAX_LEN  = 16;
  localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;

  // Width of frame_count / err_count.
  localparam int         CNT_W = 8;

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf
//   DEPTH x 8 simple dual-port payload buffer. One write port and one
//   registered read port; the read register holds its value while rd_en=0.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset (read register)
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr      read request; rd_data updates on the next edge
//   rd_data            registered read data
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: the storage array is deliberately not reset; every location is
  // written before it is read, and a reset would forbid mapping to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The read register is reset so the block output starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Pops bytes from a UART RX FIFO and delineates frames of the form
//   SOF, LEN, payload[LEN], XOR checksum (LEN ^ all payload bytes).
//   The payload is buffered and streamed out only after the checksum
//   matches. Length, checksum and inter-byte timeout errors are pulsed
//   and counted; good delivered frames are counted.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   rx_empty, rx_data  FIFO status and read data (valid cycle after rx_rd_en)
//   rx_rd_en           single-cycle FIFO pop
//   out_data/out_valid/out_ready/out_last   payload stream, valid/ready
//   err_len, err_chk, err_timeout           one-cycle error pulses
//   frame_count        delivered good frames (wraps)
//   err_count          total errors (saturates)
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int         MAX_LEN  = DEFAULT_MAX_LEN,
  parameter logic [7:0] SOF_BYTE = DEFAULT_SOF_BYTE,
  parameter int         TIMEOUT  = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_empty,
  input  logic [7:0]       rx_data,
  output logic             rx_rd_en,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             err_len,
  output logic             err_chk,
  output logic             err_timeout,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int            AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_next;
  logic          rd_pend;      // a pop was issued last cycle
  logic          byte_vld;     // rx_data carries a consumed byte this cycle
  logic [7:0]    chk;
  logic [AW-1:0] len_m1;       // payload length minus one
  logic [AW-1:0] wptr, rptr, rptr_inc;
  logic [TW-1:0] tcnt;
  logic          in_frame, len_bad, to_hit, hs, hs_last, chk_pass;
  logic          set_err_len, set_err_chk, set_err_to;
  logic          buf_wr, buf_rd;
  logic [AW-1:0] buf_raddr;

  assign byte_vld = rd_pend;
  assign in_frame = (state inside {LEN, PAYLOAD, CHK});
  assign len_bad  = (rx_data == 8'd0) || (int'(rx_data) > MAX_LEN);
  assign rptr_inc = rptr + 1'b1;
  assign hs       = (state == DRAIN) && out_valid && out_ready;
  assign hs_last  = (rptr == len_m1);
  // The counter would reach TIMEOUT on this edge unless a byte arrives.
  assign to_hit   = in_frame && !byte_vld && (tcnt == TO_LAST);

  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    chk_pass    = 1'b0;
    set_err_len = 1'b0;
    set_err_chk = 1'b0;
    set_err_to  = to_hit;
    buf_wr      = 1'b0;
    buf_rd      = 1'b0;
    buf_raddr   = rptr_inc;
    // Pops are gated by reset so nothing is drained from the FIFO while
    // the block is held in reset.
    rx_rd_en    = reset && !rx_empty && !rd_pend && (state != DRAIN);

    unique case (state)
      HUNT: begin
        if (byte_vld && rx_data == SOF_BYTE) state_next = LEN;
      end
      LEN: begin
        if (byte_vld) begin
          set_err_len = len_bad;
          state_next  = len_bad ? HUNT : PAYLOAD;
        end else if (to_hit) begin
          state_next = HUNT;
        end
      end
      PAYLOAD: begin
        if (byte_vld) begin
          buf_wr = 1'b1;
          if (wptr == len_m1) state_next = CHK;
        end else if (to_hit) begin
          state_next = HUNT;
        end
      end
      CHK: begin
        if (byte_vld) begin
          chk_pass    = (rx_data == chk);
          set_err_chk = !chk_pass;
          state_next  = chk_pass ? DRAIN : HUNT;
          // Prefetch the first payload byte so out_data is ready together
          // with out_valid.
          buf_rd      = chk_pass;
          buf_raddr   = '0;
        end else if (to_hit) begin
          state_next = HUNT;
        end
      end
      DRAIN: begin
        if (hs) begin
          if (hs_last) state_next = HUNT;
          else         buf_rd     = 1'b1;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HUNT;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend     <= 1'b0;
      chk         <= '0;
      len_m1      <= '0;
      wptr        <= '0;
      rptr        <= '0;
      tcnt        <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      err_len     <= 1'b0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      rd_pend     <= rx_rd_en;
      err_len     <= set_err_len;
      err_chk     <= set_err_chk;
      err_timeout <= set_err_to;
      out_valid   <= (state_next == DRAIN);

      if (!in_frame || byte_vld || to_hit) tcnt <= '0;
      else                                 tcnt <= tcnt + 1'b1;

      unique case (state)
        HUNT: if (byte_vld && rx_data == SOF_BYTE) chk <= '0;
        LEN: if (byte_vld && !len_bad) begin
          len_m1 <= AW'(rx_data - 8'd1);
          chk    <= rx_data;
          wptr   <= '0;
        end
        PAYLOAD: if (byte_vld) begin
          chk  <= chk ^ rx_data;
          wptr <= wptr + 1'b1;
        end
        CHK: if (chk_pass) begin
          rptr     <= '0;
          out_last <= (len_m1 == '0);
        end
        DRAIN: if (hs) begin
          rptr     <= rptr_inc;
          out_last <= !hs_last && (rptr_inc == len_m1);
        end
        default: ;
      endcase

      if (hs && hs_last) frame_count <= frame_count + 1'b1;
      if ((set_err_len || set_err_chk || set_err_to) && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (reset),
    .wr_en   (buf_wr),
    .wr_addr (wptr),
    .wr_data (rx_data),
    .rd_en   (buf_rd),
    .rd_addr (buf_raddr),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser
//   Drives the parser from a queue-based RX FIFO model. Each byte stream is
//   fed through a frame-level reference parser that pushes the expected
//   output bytes and error events into a scoreboard queue; a monitor pops
//   and compares whenever the DUT presents a handshake or an error pulse.
//   A GAP token in a stream means "stay idle longer than the timeout".
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int SOF     = 'hA5;
  localparam int TIMEOUT = 40;
  localparam int GAP     = -1;
  localparam int EV_DATA = 0;
  localparam int EV_LEN  = 1;
  localparam int EV_CHK  = 2;
  localparam int EV_TO   = 3;

  typedef struct {
    int kind;
    int data;
    int last;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       rx_rd_en;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       err_len;
  logic       err_chk;
  logic       err_timeout;
  logic [7:0] frame_count;
  logic [7:0] err_count;

  int         checks       = 0;
  int         errors       = 0;
  int         cyc          = 0;
  int         last_pop_cyc = 0;
  int         model_frames = 0;
  int         model_errs   = 0;
  int         ready_mode   = 0;   // 0: always ready, 1: toggle, 2: random
  bit         pop_req      = 1'b0;
  ev_t        exp_q[$];
  logic [7:0] fifo_q[$];

  uart_frame_parser #(
    .MAX_LEN  (MAX_LEN),
    .SOF_BYTE (8'hA5),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_empty    (rx_empty),
    .rx_data     (rx_data),
    .rx_rd_en    (rx_rd_en),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .err_len     (err_len),
    .err_chk     (err_chk),
    .err_timeout (err_timeout),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_ev(input int kind, input int data, input int last);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.last = last;
    exp_q.push_back(e);
    if (kind != EV_DATA && model_errs < 255) model_errs++;
  endtask

  task automatic model_parse(input int tok[$]);
    int i, n, len, sum;
    int pay[$];
    bit aborted;
    i = 0;
    n = tok.size();
    while (i < n) begin
      if (tok[i] != SOF) begin i++; continue; end        // noise or idle while hunting
      i++;
      if (i >= n) break;
      if (tok[i] == GAP) begin push_ev(EV_TO, 0, 0); i++; continue; end
      len = tok[i];
      i++;
      if (len == 0 || len > MAX_LEN) begin push_ev(EV_LEN, 0, 0); continue; end
      sum = len;
      pay.delete();
      aborted = 1'b0;
      for (int k = 0; k < len; k++) begin
        if (i >= n) begin aborted = 1'b1; break; end
        if (tok[i] == GAP) begin push_ev(EV_TO, 0, 0); i++; aborted = 1'b1; break; end
        pay.push_back(tok[i]);
        sum = sum ^ tok[i];
        i++;
      end
      if (aborted) continue;
      if (i >= n) break;
      if (tok[i] == GAP) begin push_ev(EV_TO, 0, 0); i++; continue; end
      if (tok[i] != sum) begin push_ev(EV_CHK, 0, 0); i++; continue; end
      i++;
      foreach (pay[k]) push_ev(EV_DATA, pay[k], (k == pay.size() - 1) ? 1 : 0);
      model_frames = (model_frames + 1) % 256;
    end
  endtask

  // ---------------- RX FIFO model ----------------
  initial begin : fifo_model
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (pop_req) begin
        check("pop_when_nonempty", int'(fifo_q.size() > 0), 1);
        if (fifo_q.size() > 0) begin
          rx_data      = fifo_q.pop_front();
          last_pop_cyc = cyc;
        end
      end
      #1 rx_empty = (fifo_q.size() == 0);
    end
  end

  initial begin : ready_driver
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !out_ready;
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic expect_event(input int kind, input int data, input int last);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", kind, -1);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == EV_DATA && e.kind == EV_DATA) begin
        check("out_data", data, e.data);
        check("out_last", last, e.last);
      end
    end
  endtask

  initial begin : monitor
    bit         hold_pend;
    logic [7:0] hold_data;
    logic       hold_last;
    int         n_err;
    hold_pend = 1'b0;
    hold_data = 8'h00;
    hold_last = 1'b0;
    forever begin
      @(negedge clk);
      pop_req = rx_rd_en;
      if (!reset) begin
        hold_pend = 1'b0;
      end else begin
        if (out_valid) check("no_pop_during_drain", int'(rx_rd_en), 0);
        if (hold_pend) begin
          check("hold_valid", int'(out_valid), 1);
          check("hold_data", int'(out_data), int'(hold_data));
          check("hold_last", int'(out_last), int'(hold_last));
        end
        hold_pend = out_valid && !out_ready;
        hold_data = out_data;
        hold_last = out_last;
        if (out_valid && out_ready) expect_event(EV_DATA, int'(out_data), int'(out_last));
        n_err = int'(err_len) + int'(err_chk) + int'(err_timeout);
        if (n_err > 0) check("err_onehot", n_err, 1);
        if (err_len) expect_event(EV_LEN, 0, 0);
        if (err_chk) expect_event(EV_CHK, 0, 0);
        if (err_timeout) begin
          expect_event(EV_TO, 0, 0);
          // Pop at cycle k, consume at edge k+1, pulse after edge k+1+TIMEOUT.
          check("timeout_latency", cyc - last_pop_cyc, TIMEOUT + 1);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_byte(input int b);
    @(posedge clk);
    #1;
    fifo_q.push_back(8'(b));
  endtask

  task automatic wait_fifo_empty();
    int n;
    n = 0;
    while (fifo_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (fifo_q.size() != 0) check("fifo_drain_budget", fifo_q.size(), 0);
  endtask

  task automatic settle(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check({tag, "_pending_events"}, exp_q.size(), 0);
    check({tag, "_frame_count"}, int'(frame_count), model_frames);
    check({tag, "_err_count"}, int'(err_count), model_errs);
  endtask

  task automatic send(input string tag, input int tok[$]);
    model_parse(tok);
    foreach (tok[i]) begin
      if (tok[i] == GAP) begin
        wait_fifo_empty();
        repeat (TIMEOUT + 10) @(posedge clk);
      end else begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        push_byte(tok[i]);
      end
    end
    settle(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_rd_en"}, int'(rx_rd_en), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check({tag, "_err_pulses"}, int'({err_len, err_chk, err_timeout}), 0);
    check({tag, "_frame_count"}, int'(frame_count), 0);
    check({tag, "_err_count"}, int'(err_count), 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin : stimulus
    int t[$];
    int kind, len, sum, b, cut;

    reset = 1'b0;
    fifo_q.push_back(8'h00);              // FIFO non-empty while in reset
    repeat (2) begin
      @(negedge clk);
      check_all_zero("reset");
    end
    @(posedge clk);
    #1 reset = 1'b1;

    // Good frame, always ready.
    ready_mode = 0;
    t = {SOF, 3, 'h11, 'h22, 'h33, 3, GAP};
    send("good", t);

    // Bad checksum, then a good frame.
    t = {SOF, 2, 'h55, 'h66, 'h00, GAP, SOF, 1, 'h42, 'h43, GAP};
    send("badchk", t);

    // LEN=0 and LEN=17, then a frame is still accepted.
    t = {SOF, 0, SOF, 'h11, SOF, 2, 'h01, 'h02, 'h01, GAP};
    send("badlen", t);

    // Noise plus back-pressure toggling every cycle.
    ready_mode = 1;
    t = {'h00, 'hFF, SOF, 1, 'h7E, 'h7F, GAP};
    send("noise_bp", t);

    // Maximum-length frame with SOF values inside the payload.
    t = {SOF, MAX_LEN};
    sum = MAX_LEN;
    for (int k = 0; k < MAX_LEN; k++) begin
      b = (k % 4 == 0) ? SOF : ((k * 37 + 5) & 'hFF);
      t.push_back(b);
      sum = sum ^ b;
    end
    t.push_back(sum);
    t.push_back(GAP);
    send("maxlen", t);

    // Inter-byte timeout, then recovery.
    ready_mode = 0;
    t = {SOF, 4, 'hAA, GAP, SOF, 1, 'h5A, 'h5B, GAP};
    send("timeout", t);

    // Randomised mixes of noise, good, bad-checksum, bad-length and
    // truncated frames under random back-pressure.
    ready_mode = 2;
    for (int s = 0; s < 30; s++) begin
      t.delete();
      repeat ($urandom_range(1, 3)) begin
        kind = $urandom_range(0, 4);
        if (kind == 0) begin
          t.push_back($urandom_range(0, 255));
        end else if (kind == 3) begin
          t.push_back(SOF);
          t.push_back(($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAX_LEN + 1, 255));
        end else begin
          len = $urandom_range(1, MAX_LEN);
          cut = (kind == 4) ? $urandom_range(0, len - 1) : len;
          t.push_back(SOF);
          t.push_back(len);
          sum = len;
          for (int k = 0; k < cut; k++) begin
            b = $urandom_range(0, 255);
            t.push_back(b);
            sum = sum ^ b;
          end
          if (kind == 4)      t.push_back(GAP);
          else if (kind == 2) t.push_back(sum ^ $urandom_range(1, 255));
          else                t.push_back(sum);
        end
      end
      t.push_back(GAP);
      send("random", t);
    end

    // Reset in the middle of a payload.
    ready_mode = 0;
    push_byte(SOF);
    push_byte(3);
    push_byte('h11);
    wait_fifo_empty();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    fifo_q.push_back(8'h00);
    exp_q.delete();
    model_frames = 0;
    model_errs   = 0;
    repeat (2) begin
      @(negedge clk);
      check_all_zero("midreset");
    end
    @(posedge clk);
    #1 reset = 1'b1;
    t = {SOF, 3, 'h11, 'h22, 'h33, 3, GAP};
    send("after_reset", t);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
